// File: rtl/alu_issue_pkg.sv
// Shared constants, FSM state type and decode helpers for the ALU issue stage.
package alu_issue_pkg;

  localparam logic [6:0] OP_REG     = 7'b0110011;
  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [6:0] FUNCT7_ALT = 7'h20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

endpackage

// File: rtl/alu_issue_stage_register_file.sv
// 32x32 integer register file: two operand read ports, a debug read port,
// one write port, x0 hardwired to zero, asynchronous clear.
module register_file (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  rs1_addr,
  output logic [31:0] rs1_data,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs2_data,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] regs_q [1:31];
  logic [31:0] regs_d [1:31];

  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != 5'd0)) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs_q[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs_q[rs2_addr];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I ALU issue stage: decodes one R/I-type ALU op at a time, drives the
// external ALU and writes its result back to rd after ALU_LATENCY cycles.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int unsigned ALU_LATENCY = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        instruction_valid,
  input  logic [31:0] instruction,
  output logic        instruction_ready,
  output logic        enable,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] register_data_1,
  output logic [31:0] register_data_2,
  input  logic [31:0] register_data_out,
  output logic        illegal_instruction,
  input  logic [4:0]  debug_address,
  output logic [31:0] debug_data
);

  localparam logic [2:0] LAT_LOAD = 3'(ALU_LATENCY);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [6:0]  funct7_q, funct7_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [4:0]  rd_q, rd_d;
  logic        illegal_q, illegal_d;

  logic [6:0]  opcode;
  logic [2:0]  dec_funct3;
  logic [31:0] rs1_data, rs2_data;
  logic        is_reg, is_imm, accept, wb_en;

  assign opcode     = instruction[6:0];
  assign dec_funct3 = instruction[14:12];
  assign is_reg     = (opcode == OP_REG);
  assign is_imm     = (opcode == OP_IMM);

  assign instruction_ready = (state_q == IDLE);
  assign accept            = instruction_valid && instruction_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    funct3_d  = funct3_q;
    funct7_d  = funct7_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    rd_d      = rd_q;
    illegal_d = 1'b0;
    wb_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_reg || is_imm) begin
            state_d  = ISSUE;
            funct3_d = dec_funct3;
            op_a_d   = rs1_data;
            rd_d     = instruction[11:7];
            if (is_reg) begin
              funct7_d = instruction[31:25];
              op_b_d   = rs2_data;
            end else begin
              // Only the shift-immediates carry a funct7 field; other I-types use those bits as immediate.
              funct7_d = ((dec_funct3 == 3'b001) || (dec_funct3 == 3'b101)) ? instruction[31:25] : '0;
              op_b_d   = imm_i(instruction);
            end
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (ALU_LATENCY == 0) begin
          wb_en   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q <= 3'd1) begin
          wb_en   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      funct3_q  <= funct3_d;
      funct7_q  <= funct7_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
    end
  end

  assign enable              = (state_q == ISSUE);
  assign funct3              = funct3_q;
  assign funct7              = funct7_q;
  assign register_data_1     = op_a_q;
  assign register_data_2     = op_b_q;
  assign illegal_instruction = illegal_q;

  register_file u_regs (
    .clock    (clock),
    .reset_n  (reset_n),
    .rs1_addr (instruction[19:15]),
    .rs1_data (rs1_data),
    .rs2_addr (instruction[24:20]),
    .rs2_data (rs2_data),
    .dbg_addr (debug_address),
    .dbg_data (debug_data),
    .wr_en    (wb_en),
    .wr_addr  (rd_q),
    .wr_data  (register_data_out)
  );

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vector table and random ops on a
// zero-latency instance, hand sequences on an ALU_LATENCY=2 instance.
module tb_alu_issue_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- instance with ALU_LATENCY = 0
  logic        rst0_n, v0, rdy0, en0, ill0;
  logic [31:0] ins0, a0, b0, out0, dbgd0;
  logic [2:0]  f30;
  logic [6:0]  f70;
  logic [4:0]  dbga0;

  // ---------------- instance with ALU_LATENCY = 2
  logic        rst2_n, v2, rdy2, en2, ill2;
  logic [31:0] ins2, a2, b2, out2, dbgd2;
  logic [2:0]  f32;
  logic [6:0]  f72;
  logic [4:0]  dbga2;

  alu_issue_stage #(.ALU_LATENCY(0)) dut0 (
    .clock(clk), .reset_n(rst0_n), .instruction_valid(v0), .instruction(ins0),
    .instruction_ready(rdy0), .enable(en0), .funct3(f30), .funct7(f70),
    .register_data_1(a0), .register_data_2(b0), .register_data_out(out0),
    .illegal_instruction(ill0), .debug_address(dbga0), .debug_data(dbgd0)
  );

  alu_issue_stage #(.ALU_LATENCY(2)) dut2 (
    .clock(clk), .reset_n(rst2_n), .instruction_valid(v2), .instruction(ins2),
    .instruction_ready(rdy2), .enable(en2), .funct3(f32), .funct7(f72),
    .register_data_1(a2), .register_data_2(b2), .register_data_out(out2),
    .illegal_instruction(ill2), .debug_address(dbga2), .debug_data(dbgd2)
  );

  // Behavioural RV32I ALU standing in for the downstream unit.
  function automatic logic [31:0] alu(input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return (f7 == 7'h20) ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return (f7 == 7'h20) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  assign out0 = alu(f30, f70, a0, b0);
  assign out2 = alu(f32, f72, a2, b2);

  logic [31:0] regs [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          en_cnt;
    int          busy;
    int          ill_cnt;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
  } obs_t;

  // Offer one instruction to dut0 and watch a fixed window; while busy, a
  // stray ADDI x7,x7,1 is offered to prove it is ignored.
  task automatic run0(input logic [31:0] instr, output obs_t o);
    o = '{0, 0, 0, 3'd0, 7'd0, 32'd0, 32'd0};
    @(negedge clk);
    v0 = 1'b1; ins0 = instr;
    @(negedge clk);
    v0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (en0) begin
        o.en_cnt++; o.f3 = f30; o.f7 = f70; o.a = a0; o.b = b0;
      end
      if (!rdy0) o.busy++;
      if (ill0) o.ill_cnt++;
      v0 = !rdy0; ins0 = 32'h00138393;
    end
    v0 = 1'b0;
  endtask

  task automatic dbg0(input logic [4:0] ad, output logic [31:0] d);
    dbga0 = ad; #1; d = dbgd0;
  endtask

  task automatic check_all_regs(input string nm);
    logic [31:0] d;
    for (int r = 0; r < 32; r++) begin
      dbg0(5'(r), d);
      chk($sformatf("%s_x%0d", nm, r), d, regs[r]);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        ill;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] rdval;
  } vec_t;

  vec_t vt [9];

  initial begin
    obs_t        o;
    logic [31:0] d, instr, ea, eb;
    logic [2:0]  ef3;
    logic [6:0]  ef7, opc;
    logic [4:0]  rs1, rs2, rd;
    int          kind, wb_at, en_seen, busy;

    vt[0] = '{32'h00500093, 1'b0, 3'd0, 7'h00, 32'd0, 32'd5,        5'd1, 32'd5};
    vt[1] = '{32'h00100093, 1'b0, 3'd0, 7'h00, 32'd0, 32'd1,        5'd1, 32'd1};
    vt[2] = '{32'h00200113, 1'b0, 3'd0, 7'h00, 32'd0, 32'd2,        5'd2, 32'd2};
    vt[3] = '{32'h002081B3, 1'b0, 3'd0, 7'h00, 32'd1, 32'd2,        5'd3, 32'd3};
    vt[4] = '{32'h40208233, 1'b0, 3'd0, 7'h20, 32'd1, 32'd2,        5'd4, 32'hFFFFFFFF};
    vt[5] = '{32'hFFF08293, 1'b0, 3'd0, 7'h00, 32'd1, 32'hFFFFFFFF, 5'd5, 32'd0};
    vt[6] = '{32'h00700013, 1'b0, 3'd0, 7'h00, 32'd0, 32'd7,        5'd0, 32'd0};
    vt[7] = '{32'h00000073, 1'b1, 3'd0, 7'h00, 32'd0, 32'd0,        5'd0, 32'd0};
    vt[8] = '{32'h40425313, 1'b0, 3'd5, 7'h20, 32'hFFFFFFFF, 32'h404, 5'd6, 32'hFFFFFFFF};

    for (int r = 0; r < 32; r++) regs[r] = '0;
    rst0_n = 1'b0; rst2_n = 1'b0;
    v0 = 1'b0; ins0 = '0; dbga0 = 5'd1;
    v2 = 1'b0; ins2 = '0; dbga2 = 5'd1;

    // ---------------- reset state of dut0
    repeat (3) @(negedge clk);
    chk("rst_enable", 32'(en0), 32'd0);
    chk("rst_funct3", 32'(f30), 32'd0);
    chk("rst_funct7", 32'(f70), 32'd0);
    chk("rst_op_a", a0, 32'd0);
    chk("rst_op_b", b0, 32'd0);
    chk("rst_illegal", 32'(ill0), 32'd0);
    rst0_n = 1'b1; #1;
    chk("rst_ready_after_release", 32'(rdy0), 32'd1);

    // ---------------- directed vector table
    for (int i = 0; i < 9; i++) begin
      run0(vt[i].instr, o);
      if (vt[i].ill) begin
        chk($sformatf("v%0d_illegal_pulses", i), 32'(o.ill_cnt), 32'd1);
        chk($sformatf("v%0d_enable_cycles", i), 32'(o.en_cnt), 32'd0);
        chk($sformatf("v%0d_busy_cycles", i), 32'(o.busy), 32'd0);
        check_all_regs($sformatf("v%0d_unchanged", i));
      end else begin
        chk($sformatf("v%0d_enable_cycles", i), 32'(o.en_cnt), 32'd1);
        chk($sformatf("v%0d_busy_cycles", i), 32'(o.busy), 32'd1);
        chk($sformatf("v%0d_illegal_pulses", i), 32'(o.ill_cnt), 32'd0);
        chk($sformatf("v%0d_funct3", i), 32'(o.f3), 32'(vt[i].f3));
        chk($sformatf("v%0d_funct7", i), 32'(o.f7), 32'(vt[i].f7));
        chk($sformatf("v%0d_op_a", i), o.a, vt[i].a);
        chk($sformatf("v%0d_op_b", i), o.b, vt[i].b);
        dbg0(vt[i].rd, d);
        chk($sformatf("v%0d_rd_value", i), d, vt[i].rdval);
        if (vt[i].rd != 5'd0) regs[vt[i].rd] = vt[i].rdval;
      end
    end

    // ---------------- random ops against the architectural model
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 8);
      rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
      ef3 = 3'($urandom);
      if (kind < 4) begin
        ef7 = ((ef3 == 3'd0 || ef3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        instr = {ef7, rs2, rs1, ef3, rd, 7'b0110011};
        ea = regs[rs1]; eb = regs[rs2];
      end else if (kind < 8) begin
        instr = {12'($urandom), rs1, ef3, rd, 7'b0010011};
        if (ef3 == 3'd5 && $urandom_range(0, 1) == 1) instr[31:25] = 7'h20;
        if (ef3 == 3'd1 || ef3 == 3'd5) ef7 = instr[31:25];
        else ef7 = 7'h00;
        ea = regs[rs1];
        eb = 32'($signed(instr[31:20]));
      end else begin
        opc = 7'($urandom);
        while (opc == 7'b0110011 || opc == 7'b0010011) opc = 7'($urandom);
        instr = {25'($urandom), opc};
        ef7 = 7'h00; ea = '0; eb = '0;
      end
      run0(instr, o);
      if (kind == 8) begin
        chk($sformatf("r%0d_illegal_pulses", n), 32'(o.ill_cnt), 32'd1);
        chk($sformatf("r%0d_enable_cycles", n), 32'(o.en_cnt), 32'd0);
        chk($sformatf("r%0d_busy_cycles", n), 32'(o.busy), 32'd0);
      end else begin
        chk($sformatf("r%0d_enable_cycles", n), 32'(o.en_cnt), 32'd1);
        chk($sformatf("r%0d_illegal_pulses", n), 32'(o.ill_cnt), 32'd0);
        chk($sformatf("r%0d_ops", n), {o.f3, o.f7, 22'd0}, {ef3, ef7, 22'd0});
        chk($sformatf("r%0d_op_a", n), o.a, ea);
        chk($sformatf("r%0d_op_b", n), o.b, eb);
        if (rd != 5'd0) regs[rd] = alu(ef3, ef7, ea, eb);
        dbg0(rd, d);
        chk($sformatf("r%0d_rd_value", n), d, regs[rd]);
      end
    end
    check_all_regs("final");

    // ---------------- ALU_LATENCY=2: timing of accept to writeback
    @(negedge clk);
    rst2_n = 1'b1; #1;
    chk("lat2_ready_after_release", 32'(rdy2), 32'd1);
    dbga2 = 5'd1;
    @(negedge clk);
    v2 = 1'b1; ins2 = 32'h00500093;
    @(negedge clk);
    v2 = 1'b0;
    wb_at = -1; en_seen = 0; busy = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (en2) begin
        en_seen++;
        chk("lat2_op_b", b2, 32'd5);
      end
      if (!rdy2) busy++;
      if (dbgd2 == 32'd5 && wb_at < 0) wb_at = k;
    end
    chk("lat2_enable_cycles", 32'(en_seen), 32'd1);
    chk("lat2_busy_cycles", 32'(busy), 32'd3);
    chk("lat2_writeback_edge", 32'(wb_at), 32'd3);

    // ---------------- ALU_LATENCY=2: reset while waiting on the ALU
    dbga2 = 5'd6;
    @(negedge clk);
    v2 = 1'b1; ins2 = 32'h00900313;
    @(negedge clk);
    v2 = 1'b0;
    @(negedge clk);
    chk("lat2_in_wait_not_ready", 32'(rdy2), 32'd0);
    rst2_n = 1'b0; #1;
    chk("lat2_rst_enable", 32'(en2), 32'd0);
    chk("lat2_rst_fields", {f32, f72, ill2}, 11'd0);
    chk("lat2_rst_op_a", a2, 32'd0);
    chk("lat2_rst_op_b", b2, 32'd0);
    chk("lat2_rst_ready", 32'(rdy2), 32'd1);
    chk("lat2_rst_x6", dbgd2, 32'd0);
    dbga2 = 5'd1; #1;
    chk("lat2_rst_x1_cleared", dbgd2, 32'd0);
    @(negedge clk);
    rst2_n = 1'b1; #1;
    chk("lat2_ready_after_abort", 32'(rdy2), 32'd1);
    dbga2 = 5'd6;
    en_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (en2) en_seen++;
    end
    chk("lat2_no_enable_after_abort", 32'(en_seen), 32'd0);
    chk("lat2_x6_not_written", dbgd2, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter ALU_LATENCY, default 0, range 0..7: cycles the downstream ALU takes after enable to present a valid register_data_out.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 instruction_valid  input  1  an RV32I instruction is offered.
REQ-005 instruction  input  32  instruction word.
REQ-006 instruction_ready  output  1  stage accepts the instruction this cycle.
REQ-007 enable  output  1  ALU operation strobe.
REQ-008 funct3  output  3  ALU operation select.
REQ-009 funct7  output  7  ALU variant select (0x00 base, 0x20 SUB/SRA).
REQ-010 register_data_1  output  32  ALU operand A (rs1 value).
REQ-011 register_data_2  output  32  ALU operand B (rs2 value or sign-extended immediate).
REQ-012 register_data_out  input  32  ALU result, written back to rd.
REQ-013 illegal_instruction  output  1  one-cycle pulse when an accepted instruction is not an ALU op.
REQ-014 debug_address  input  5  register-file debug read index.
REQ-015 debug_data  output  32  combinational read of register debug_address (x0 reads 0).

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE and WAIT; instruction_ready = (state==IDLE), combinational.
REQ-017 On instruction_valid && instruction_ready, the stage SHALL decode the instruction, read rs1/rs2 and register funct3, funct7 and both operands.
REQ-018 R-type (opcode 0110011): funct7=instr[31:25], funct3=instr[14:12], operand B = x[rs2].
REQ-019 I-type ALU (opcode 0010011): operand B = sign-extended instr[31:20]; funct7=instr[31:25] when funct3 is 001 or 101, otherwise 0.
REQ-020 Any other opcode SHALL be consumed; illegal_instruction pulses the following cycle; state stays IDLE; enable and the operand registers do not change.
REQ-021 A legal accept SHALL enter ISSUE; enable=1 for exactly that one cycle.
REQ-022 If ALU_LATENCY=0, the edge ending ISSUE SHALL write register_data_out to rd and return to IDLE.
REQ-023 If ALU_LATENCY=N>0, ISSUE SHALL go to WAIT with a 3-bit counter loaded to N; the edge where the counter reaches 1 SHALL write back and return to IDLE.
REQ-024 funct3, funct7 and both operands SHALL hold stable from ISSUE through the writeback edge.
REQ-025 Writes to x0 SHALL be discarded; x0 SHALL always read 0.
REQ-026 instruction_valid outside IDLE SHALL be ignored; no RAW hazard exists because writeback completes before the next accept.
REQ-027 Throughput SHALL be one instruction per 2+ALU_LATENCY cycles.

Reset
REQ-028 reset_n low SHALL immediately force state=IDLE, counter=0, enable=0, funct3=0, funct7=0, register_data_1=0, register_data_2=0, illegal_instruction=0 and all 32 registers to 0.
REQ-029 A reset during ISSUE or WAIT SHALL abandon the operation with no writeback.
REQ-030 After reset release, instruction_ready SHALL be 1 in the first cycle.

Structure
REQ-031 The package alu_issue_pkg SHALL hold the opcode constants (OP_REG=7'b0110011, OP_IMM=7'b0010011), the FUNCT7_ALT=7'h20 constant and the state enum.
REQ-032 A sub-module register_file SHALL hold the 32x32 array, with two combinational read ports, a debug read port, a single write port, hardwiring of x0 and asynchronous clearing.

Verification
REQ-033 After reset, drive 0x00500093 (ADDI x1,x0,5) with the model ALU returning 5 -> the next cycle shows enable=1, funct3=0, funct7=0, operand A=0, operand B=5, and debug x1=5 after writeback.
REQ-034 With x1=1 and x2=2, drive 0x002081B3 (ADD x3) and then 0x40208233 (SUB x4) -> operands 1 and 2 each time, funct7 0x00 then 0x20, and x3=3, x4=0xFFFFFFFF.
REQ-035 Drive 0xFFF08293 (ADDI x5,x1,-1) -> operand B=0xFFFFFFFF; then 0x00700013 (ADDI x0,x0,7) -> x0 still reads 0.
REQ-036 Drive 0x00000073 -> illegal_instruction is high for exactly 1 cycle, enable stays 0, instruction_ready stays 1 and no register changes.
REQ-037 With ALU_LATENCY=2: accept, then enable is high for 1 cycle, writeback occurs 3 edges after the accept edge and instruction_ready is low for exactly 3 cycles.
REQ-038 With ALU_LATENCY=2, assert reset_n low in WAIT -> outputs are 0 immediately, rd is not written and the stage is ready after release.
